// File: rtl/riscv_data_mem.sv
// riscv_data_mem: word-organised data memory with byte-enable writes and a
// fixed number of wait states. The request bundle is captured on accept, the
// array access happens on the edge entering DONE, and every output is a flop.
module riscv_data_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_be_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wd_i,
    output logic [31:0] mem_rd_o,
    output logic        mem_ready_o,
    output logic        mem_fault_o
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rd_q, rd_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;

    logic [31:0] mem_array [DEPTH_WORDS];

    // Operands of the access: live inputs when committing straight from IDLE
    // (zero wait states), otherwise the values captured at accept.
    logic             acc_we;
    logic [3:0]       acc_be;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wd;
    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] word_idx;
    logic             commit;
    logic             mem_wr_en;

    // Select access operands and decode the address against the window.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path can leave it unassigned and infer a latch.
        acc_we   = we_q;
        acc_be   = be_q;
        acc_addr = addr_q;
        acc_wd   = wd_q;
        if (state_q == IDLE) begin
            acc_we   = mem_we_i;
            acc_be   = mem_be_i;
            acc_addr = mem_addr_i;
            acc_wd   = mem_wd_i;
        end
        offset   = acc_addr - BASE_ADDR;
        in_range = (offset < SPAN_BYTES);
        word_idx = offset[IDX_W+1:2];
    end

    // Next-state, capture and output logic of the IDLE/WAIT/DONE sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        ready_d = 1'b0;
        fault_d = 1'b0;
        commit  = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    we_d   = mem_we_i;
                    be_d   = mem_be_i;
                    addr_d = mem_addr_i;
                    wd_d   = mem_wd_i;
                    if (WAIT_STATES == 0) begin
                        commit  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            ready_d = 1'b1;
            fault_d = ~in_range;
            if (!acc_we) begin
                rd_d = in_range ? mem_array[word_idx] : 32'h0;
            end
        end

        // Reset outranks a commit landing on the same edge.
        mem_wr_en = commit & acc_we & in_range & ~rst_i;
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            addr_q  <= 32'h0;
            wd_q    <= 32'h0;
            rd_q    <= 32'h0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
        end
    end

    // Byte-lane write port of the storage array.
    always_ff @(posedge clk_i) begin
        // NOTE: the array has no reset; clearing it would cost a write cycle
        // per word and software never relies on its initial contents.
        if (mem_wr_en) begin
            for (int n = 0; n < 4; n++) begin
                if (acc_be[n]) begin
                    mem_array[word_idx][8*n +: 8] <= acc_wd[8*n +: 8];
                end
            end
        end
    end

    assign mem_rd_o    = rd_q;
    assign mem_ready_o = ready_q;
    assign mem_fault_o = fault_q;

endmodule

// File: tb/tb_riscv_data_mem.sv
// Testbench for riscv_data_mem: four instances with different wait states,
// depths and base addresses, driven by directed and random accesses and
// checked against a byte-level reference model of the memory.
module tb_riscv_data_mem;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [N];
    logic        req   [N];
    logic        we    [N];
    logic [3:0]  be    [N];
    logic [31:0] addr  [N];
    logic [31:0] wd    [N];
    logic [31:0] rd    [N];
    logic        rdy   [N];
    logic        flt   [N];

    // Instance configuration, mirrored for the reference model.
    int unsigned ws_p    [N] = '{1, 0, 3, 15};
    int unsigned depth_p [N] = '{1024, 16, 1024, 1024};
    logic [31:0] base_p  [N] = '{32'h0, 32'h0, 32'h1000, 32'h0};

    riscv_data_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .mem_req_i(req[0]), .mem_we_i(we[0]), .mem_be_i(be[0]),
        .mem_addr_i(addr[0]), .mem_wd_i(wd[0]), .mem_rd_o(rd[0]), .mem_ready_o(rdy[0]),
        .mem_fault_o(flt[0]));
    riscv_data_mem #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .mem_req_i(req[1]), .mem_we_i(we[1]), .mem_be_i(be[1]),
        .mem_addr_i(addr[1]), .mem_wd_i(wd[1]), .mem_rd_o(rd[1]), .mem_ready_o(rdy[1]),
        .mem_fault_o(flt[1]));
    riscv_data_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1000), .WAIT_STATES(3)) u_dut2 (
        .clk_i(clk), .rst_i(rst[2]), .mem_req_i(req[2]), .mem_we_i(we[2]), .mem_be_i(be[2]),
        .mem_addr_i(addr[2]), .mem_wd_i(wd[2]), .mem_rd_o(rd[2]), .mem_ready_o(rdy[2]),
        .mem_fault_o(flt[2]));
    riscv_data_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(15)) u_dut3 (
        .clk_i(clk), .rst_i(rst[3]), .mem_req_i(req[3]), .mem_we_i(we[3]), .mem_be_i(be[3]),
        .mem_addr_i(addr[3]), .mem_wd_i(wd[3]), .mem_rd_o(rd[3]), .mem_ready_o(rdy[3]),
        .mem_fault_o(flt[3]));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: known bytes keyed by instance and byte offset, plus
    // the expected value of each instance's read-data register.
    logic [7:0]  mdl [int];
    logic [31:0] exp_rd   [N];
    bit          rd_known [N];

    // One complete transaction on instance k, checked against the model.
    // With drop set, req falls and every other input changes after accept.
    task automatic access(input int k, input bit w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d, input bit drop,
                          input string tag, output logic [31:0] got_rd);
        logic [31:0] off;
        logic [31:0] word;
        bit          inr;
        bit          all_known;
        int          key;
        int          lat;

        off = a - base_p[k];
        inr = longint'(off) < longint'(depth_p[k]) * 4;
        key = k * (1 << 20) + int'(off >> 2) * 4;
        word = 32'h0;
        if (!inr) begin
            if (!w) begin
                exp_rd[k]   = 32'h0;
                rd_known[k] = 1'b1;
            end
        end else if (w) begin
            for (int n = 0; n < 4; n++) begin
                if (b[n]) mdl[key + n] = d[8*n +: 8];
            end
        end else begin
            all_known = 1'b1;
            for (int n = 0; n < 4; n++) begin
                if (mdl.exists(key + n)) word[8*n +: 8] = mdl[key + n];
                else all_known = 1'b0;
            end
            exp_rd[k]   = word;
            rd_known[k] = all_known;
        end

        we[k] = w; be[k] = b; addr[k] = a; wd[k] = d; req[k] = 1'b1;
        @(posedge clk); #1;
        if (drop) begin
            req[k] = 1'b0; we[k] = ~w; be[k] = ~b; addr[k] = a + 32'd4; wd[k] = ~d;
        end
        lat = 1;
        while (!rdy[k] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(ws_p[k] + 1));
        check({tag, "_fault"}, {31'b0, flt[k]}, {31'b0, ~inr});
        if (rd_known[k]) check({tag, "_rd"}, rd[k], exp_rd[k]);
        got_rd = rd[k];
        req[k] = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ready_one_cycle"}, {31'b0, rdy[k]}, 32'h0);
    endtask

    // Hold a read request continuously and measure the ready pulse period.
    task automatic stream(input int k, input int pulses);
        int  cyc;
        int  last;
        int  got;
        bit  prev;
        we[k] = 1'b0; be[k] = 4'hF; addr[k] = base_p[k]; req[k] = 1'b1;
        cyc = 0; last = -1; got = 0; prev = 1'b0;
        while (got < pulses && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
            if (rdy[k]) begin
                check($sformatf("stream%0d_no_back_to_back", k), {31'b0, prev}, 32'h0);
                if (last >= 0) check($sformatf("stream%0d_period", k), 32'(cyc - last), 32'(ws_p[k] + 2));
                last = cyc;
                got++;
            end
            prev = rdy[k];
        end
        check($sformatf("stream%0d_pulses", k), 32'(got), 32'(pulses));
        req[k] = 1'b0;
        @(posedge clk); #1;
        rd_known[k] = 1'b0;
    endtask

    logic [31:0] r;

    initial begin
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0;
            addr[k] = 32'h0; wd[k] = 32'h0;
            exp_rd[k] = 32'h0; rd_known[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b0;
            check($sformatf("reset%0d_ready", k), {31'b0, rdy[k]}, 32'h0);
            check($sformatf("reset%0d_fault", k), {31'b0, flt[k]}, 32'h0);
            check($sformatf("reset%0d_rd", k), rd[k], 32'h0);
        end

        // Word write then read.
        access(0, 1, 4'hF, 32'h10, 32'hDEAD_BEEF, 0, "word_wr", r);
        access(0, 0, 4'hF, 32'h10, 32'h0, 0, "word_rd", r);
        check("word_rd_value", r, 32'hDEAD_BEEF);

        // Byte and halfword lanes.
        access(0, 1, 4'hF, 32'h20, 32'h1122_3344, 0, "lane_pre", r);
        access(0, 1, 4'b0100, 32'h20, 32'hAAAA_AAAA, 0, "lane_b2", r);
        access(0, 1, 4'b0011, 32'h22, 32'h5555_5555, 0, "lane_h0", r);
        access(0, 0, 4'b0001, 32'h20, 32'h0, 0, "lane_rd", r);
        check("lane_value", r, 32'h11AA_5555);
        access(0, 1, 4'b0000, 32'h20, 32'h0F0F_0F0F, 0, "lane_be0", r);
        access(0, 0, 4'hF, 32'h20, 32'h0, 0, "lane_rd2", r);
        check("lane_be0_value", r, 32'h11AA_5555);

        // Request drop with inputs changed after accept.
        access(0, 1, 4'hF, 32'h0C, 32'h0C0C_0C0C, 0, "drop_pre", r);
        access(0, 1, 4'hF, 32'h08, 32'h0000_0001, 1, "drop_wr", r);
        access(0, 0, 4'hF, 32'h08, 32'h0, 0, "drop_rd8", r);
        check("drop_value8", r, 32'h0000_0001);
        access(0, 0, 4'hF, 32'h0C, 32'h0, 0, "drop_rdc", r);
        check("drop_valuec", r, 32'h0C0C_0C0C);

        // Out-of-range window on the offset-base instance.
        access(2, 1, 4'hF, 32'h1000, 32'h0BAD_F00D, 0, "oor_pre0", r);
        access(2, 1, 4'hF, 32'h1FFC, 32'h7777_0001, 0, "oor_pre1", r);
        access(2, 0, 4'hF, 32'h0FFC, 32'h0, 0, "oor_rd_lo", r);
        check("oor_rd_lo_zero", r, 32'h0);
        access(2, 1, 4'hF, 32'h1FFC, 32'h0, 0, "oor_refill", r);
        access(2, 1, 4'hF, 32'h1FFC, 32'h7777_0001, 0, "oor_refill2", r);
        access(2, 0, 4'hF, 32'h1FFC, 32'h0, 0, "oor_rd_top", r);
        check("oor_rd_top_value", r, 32'h7777_0001);
        access(2, 1, 4'hF, 32'h2000, 32'hFFFF_FFFF, 0, "oor_wr", r);
        check("oor_wr_rd_held", r, 32'h7777_0001);
        access(2, 0, 4'hF, 32'h2000, 32'h0, 0, "oor_rd_hi", r);
        check("oor_rd_hi_zero", r, 32'h0);
        access(2, 0, 4'hF, 32'h1000, 32'h0, 0, "oor_alias", r);
        check("oor_alias_value", r, 32'h0BAD_F00D);
        access(1, 1, 4'hF, 32'h00, 32'h1357_9BDF, 0, "small_pre", r);
        access(1, 1, 4'hF, 32'h40, 32'hFFFF_FFFF, 0, "small_oor_wr", r);
        access(1, 0, 4'hF, 32'h00, 32'h0, 0, "small_rd", r);
        check("small_alias_value", r, 32'h1357_9BDF);

        // Reset during WAIT drops the write and clears the outputs.
        access(2, 1, 4'hF, 32'h1040, 32'hCAFE_0001, 0, "rst_pre", r);
        we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h1040; wd[2] = 32'h1234_5678; req[2] = 1'b1;
        @(posedge clk); #1;
        req[2] = 1'b0;
        @(posedge clk); #1;
        rst[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        check("rst_wait_ready", {31'b0, rdy[2]}, 32'h0);
        check("rst_wait_fault", {31'b0, flt[2]}, 32'h0);
        check("rst_wait_rd", rd[2], 32'h0);
        begin
            int pulses = 0;
            repeat (20) begin
                @(posedge clk); #1;
                if (rdy[2]) pulses++;
            end
            check("rst_wait_no_ready", 32'(pulses), 32'h0);
        end
        exp_rd[2] = 32'h0; rd_known[2] = 1'b1;
        access(2, 0, 4'hF, 32'h1040, 32'h0, 0, "rst_rd", r);
        check("rst_word_kept", r, 32'hCAFE_0001);

        // Reset landing exactly on the commit edge.
        we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h1040; wd[2] = 32'h8765_4321; req[2] = 1'b1;
        @(posedge clk); #1;
        req[2] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        check("rst_commit_ready", {31'b0, rdy[2]}, 32'h0);
        check("rst_commit_rd", rd[2], 32'h0);
        exp_rd[2] = 32'h0; rd_known[2] = 1'b1;
        access(2, 0, 4'hF, 32'h1040, 32'h0, 0, "rst_commit_rd2", r);
        check("rst_commit_word_kept", r, 32'hCAFE_0001);

        // Back-to-back throughput with req held high.
        for (int k = 0; k < N; k++) stream(k, 4);

        // Randomized accesses around each instance's window edges.
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 40; i++) begin
                int          sel;
                int          wi;
                logic [31:0] a;
                sel = int'($urandom_range(0, 9));
                if (sel < 6)      wi = int'($urandom_range(0, 7));
                else if (sel < 8) wi = int'(depth_p[k]) - 4 + int'($urandom_range(0, 7));
                else              wi = -int'($urandom_range(1, 3));
                a = base_p[k] + 32'(wi * 4) + 32'($urandom_range(0, 3));
                access(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom,
                       ($urandom_range(0, 3) == 0), $sformatf("rand%0d_%0d", k, i), r);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_data_mem.md
# riscv_data_mem

Word-organised data memory with byte-enable writes and a programmable number of wait states, sitting directly downstream of the load/store unit on the memory protocol. It consumes the request/write-enable/byte-enable/address/write-data bundle the LSU drives and returns read data plus a one-cycle ready pulse that releases the LSU stall. Out-of-range accesses complete normally but are flagged and have no side effects.

## Interface

Parameters:

- DEPTH_WORDS, 1024: number of 32-bit words; power of two, 16..65536.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
- WAIT_STATES, 1: extra cycles inserted before completion; 0..15.

Ports:

- clk_i, input, 1: single clock; all state updates on the rising edge.
- rst_i, input, 1: reset, synchronous and active-high.
- mem_req_i, input, 1: access request; held high by the requester until ready.
- mem_we_i, input, 1: 1 = write, 0 = read.
- mem_be_i, input, 4: byte enables, bit n selects byte lane n (bits 8n+7:8n).
- mem_addr_i, input, 32: byte address; bits [1:0] ignored.
- mem_wd_i, input, 32: write data, already lane-replicated by the LSU.
- mem_rd_o, output, 32: registered read data; valid while mem_ready_o = 1.
- mem_ready_o, output, 1: one-cycle completion pulse.
- mem_fault_o, output, 1: pulses with mem_ready_o when the access was out of range.

## Operation

- FSM states are IDLE, WAIT and DONE; the reset state is IDLE.
- IDLE:
  - When mem_req_i = 1, latch we, be, addr and wd into internal registers (the "accept").
  - Go to DONE if WAIT_STATES = 0; otherwise go to WAIT with the counter loaded to WAIT_STATES-1.
  - When mem_req_i = 0, stay in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, perform the access at that edge and go to DONE.
- Access, performed at the edge entering DONE and using the latched values only:
  - Offset = addr - BASE_ADDR (32-bit unsigned). The access is in range iff offset < DEPTH_WORDS*4. Word index = offset[log2(DEPTH_WORDS)+1:2].
  - Write, in range: each lane n with be[n] = 1 takes wd[8n+7:8n]; other lanes are unchanged. be = 4'b0000 writes nothing. mem_rd_o is not updated.
  - Read, in range: mem_rd_o takes the full word. be is ignored, because the LSU selects and extends the lanes.
  - Out of range: no array change. On a read, mem_rd_o takes 32'h0. On a write, mem_rd_o is unchanged. In both cases mem_fault_o = 1 in DONE.
- DONE:
  - mem_ready_o = 1 for exactly this cycle.
  - Always go to IDLE next, regardless of mem_req_i.
- No abort: if mem_req_i drops after the accept, the transaction still completes and pulses ready.
- Changes to mem_addr_i, mem_wd_i or mem_be_i after the accept are ignored.
- The array is not reset; its contents are undefined until written. Array width is DEPTH_WORDS x 32.

## Timing

- Reset values: mem_ready_o = 0, mem_fault_o = 0, mem_rd_o = 32'h0, state = IDLE, counter = 0.
- Latency: with the accept at the edge ending cycle T, mem_ready_o is high in cycle T+1+WAIT_STATES.
- Throughput: one access per WAIT_STATES+2 cycles.
- Back-to-back: if mem_req_i is still high in the IDLE cycle after DONE, it is accepted as a new transaction. This matches the LSU, which keeps mem_req_i high through the next instruction's access.
- mem_rd_o holds its value after DONE until the next read completes.
- Reset mid-transaction (WAIT or DONE): return to IDLE and clear the outputs at that edge. A write whose commit edge coincides with reset is dropped; rst_i has priority over the commit.
- Every output is a register; there is no combinational path from any input to any output.

## Test plan

- Word write then read, WAIT_STATES=1, BASE_ADDR=0:
  - Write 32'hDEAD_BEEF to 0x10 with be=4'hF: ready pulses 2 cycles after the accept.
  - Read 0x10: mem_rd_o = 32'hDEAD_BEEF in the ready cycle; fault stays 0.
- Byte and halfword lanes:
  - Preload 0x20 with 32'h1122_3344.
  - Write wd=32'hAAAA_AAAA with be=4'b0100, then wd=32'h5555_5555 with be=4'b0011.
  - Read back 0x20 = 32'h11AA_5555. A write with be=0 leaves 32'h11AA_5555.
- Latency sweep:
  - WAIT_STATES = 0, 3, 15 give ready at accept+1, +4, +16.
  - With mem_req_i held high continuously, ready pulses every 2, 5 and 17 cycles.
  - ready is never high for 2 consecutive cycles.
- Out of range, DEPTH_WORDS=1024, BASE_ADDR=0x1000:
  - Read 0x0FFC and read 0x2000: rd = 0 and fault = 1 with ready.
  - Write 0x2000: the array is unchanged. Read 0x1FFC: in range, fault = 0.
- Request drop and latched inputs:
  - Accept a write to 0x08 with wd=32'h1.
  - On the next cycle deassert req and change addr to 0x0C and wd to 32'h2.
  - Ready still pulses; 0x08 = 32'h1; 0x0C is untouched.
- Reset mid-write, WAIT_STATES=3:
  - Assert rst_i for one cycle during WAIT.
  - No ready pulse occurs, all outputs read 0 the next cycle, and the target word keeps its old value.
